// File: rtl/karatsuba_seq_mul_16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_pkg
// Description : Shared widths, state encoding and step helpers for the
//               sequential 16x16 multiplier built on one 8x8 core.
// Revision    : 1.0 - initial release
// ============================================================================
package karatsuba_pkg;

  // Operand and product widths of the sequential multiplier
  localparam int OP_W   = 16;
  localparam int PROD_W = 2 * OP_W;

  // Width of the shared sub-multiplier operands
  localparam int HW     = OP_W / 2;

  // Number of partial-product cycles per operation
  localparam int NSTEP  = 4;

  // State encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_CALC = CALC,
    ST_DONE = DONE
  } state_t;

  // Left shift applied to the partial product of a given step:
  // lo*lo -> 0, cross terms -> 8, hi*hi -> 16
  function automatic logic [4:0] step_shift(input logic [1:0] step);
    logic [4:0] sh;
    case (step)
      2'd0:    sh = 5'd0;
      2'd3:    sh = 5'd16;
      default: sh = 5'd8;
    endcase
    return sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/karatsuba_seq_mul_16_if.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_seq_mul_16_if
// Description : Operand (valid/ready) and result (valid/ready) channels of
//               the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface karatsuba_seq_mul_16_if;
  import karatsuba_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     A;
  logic [OP_W-1:0]     B;
  logic                out_valid;
  logic                out_ready;
  logic [PROD_W-1:0]   C;

  // Producer/consumer side
  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, C
  );

  // Multiplier side
  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, C
  );

endinterface
`default_nettype wire

// File: rtl/karatsuba_seq_mul_16_mul8.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_mul_8
// Description : Combinational 8x8 unsigned multiplier, one Karatsuba level
//               over 4-bit halves (three 4/5-bit products).
// Revision    : 1.0 - initial release
// ============================================================================
module karatsuba_mul_8 (
  input  wire logic [7:0]  a,
  input  wire logic [7:0]  b,
  output      logic [15:0] p
);

  logic [7:0]  z0;
  logic [7:0]  z2;
  logic [4:0]  sa;
  logic [4:0]  sb;
  logic [9:0]  zm;
  logic [9:0]  z1;

  // Karatsuba recombination: p = z2<<8 + (zm - z0 - z2)<<4 + z0
  always_comb begin
    z0 = a[3:0] * b[3:0];
    z2 = a[7:4] * b[7:4];
    sa = {1'b0, a[3:0]} + {1'b0, a[7:4]};
    sb = {1'b0, b[3:0]} + {1'b0, b[7:4]};
    zm = sa * sb;
    // Middle term is al*bh + ah*bl, at most 450, so it fits in 10 bits
    z1 = zm - {2'b00, z0} - {2'b00, z2};
    p  = {z2, z0} + {2'b00, z1, 4'b0000};
  end

endmodule
`default_nettype wire

// File: rtl/karatsuba_seq_mul_16.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_seq_mul_16
// Description : Multi-cycle 16x16 unsigned multiplier. One shared 8x8
//               Karatsuba core produces four partial products over four
//               cycles, which are shifted and summed into a 32-bit result.
// Revision    : 1.0 - initial release
// ============================================================================
module karatsuba_seq_mul_16
  import karatsuba_pkg::*;
#(
  // Only 16 is supported: must be twice the sub-multiplier width
  parameter int M = 16,
  parameter int N = 2 * M
) (
  input  wire logic             clk,
  input  wire logic             rst,
  karatsuba_seq_mul_16_if.slave bus
);

  state_t          state;
  state_t          state_next;
  logic [1:0]      step;
  logic [M-1:0]    a_q;
  logic [M-1:0]    b_q;
  logic [N-1:0]    acc;
  logic [N-1:0]    c_q;

  logic            in_ready;
  logic            out_valid;
  logic            accept;

  logic [HW-1:0]   op_a;
  logic [HW-1:0]   op_b;
  logic [2*HW-1:0] prod;
  logic [N-1:0]    addend;
  logic [N-1:0]    sum;

  assign accept = bus.in_valid && in_ready;

  // Select which halves feed the shared core on each step
  always_comb begin
    op_a = step[0] ? a_q[M-1:HW] : a_q[HW-1:0];
    op_b = step[1] ? b_q[M-1:HW] : b_q[HW-1:0];
  end

  karatsuba_mul_8 u_mul8 (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // Shift the partial product into place and add; carry past bit 31 cannot occur
  always_comb begin
    addend = {{(N-2*HW){1'b0}}, prod} << step_shift(step);
    sum    = acc + addend;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (step == 2'(NSTEP - 1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture, partial-product accumulation and result hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= 2'd0;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      c_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q  <= bus.A;
            b_q  <= bus.B;
            acc  <= '0;
            step <= 2'd0;
          end
        end
        ST_CALC: begin
          acc  <= sum;
          step <= step + 2'd1;
          if (step == 2'(NSTEP - 1)) begin
            c_q <= sum;
          end
        end
        default: begin
          // DONE: C is held; it keeps its value after the handshake too
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.C         = c_q;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_seq_mul_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_karatsuba_seq_mul_16
// Description : Directed self-checking bench for karatsuba_seq_mul_16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_karatsuba_seq_mul_16;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  karatsuba_seq_mul_16_if bus ();

  karatsuba_seq_mul_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Present operands before an edge; they are accepted on that edge
  task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input string tag);
    @(negedge clk);
    check({tag, "_in_ready_before"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
  endtask

  // Four CALC edges after acceptance the result is presented
  task automatic expect_result(input logic [31:0] exp, input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_out_valid_early"}, {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_C"}, bus.C, exp);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_clear"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b0;

    // Reset values
    #2;
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_C", bus.C, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic product
    accept_op(16'h1234, 16'h5678, "basic");
    expect_result(32'h06260060, "basic");
    handshake("basic");

    // Maxima
    accept_op(16'hFFFF, 16'hFFFF, "max");
    expect_result(32'hFFFE0001, "max");
    handshake("max");

    // Zero operand, same latency
    accept_op(16'h0000, 16'hBEEF, "zero");
    expect_result(32'h00000000, "zero");
    handshake("zero");

    // Backpressure: result held for 7 cycles without out_ready
    accept_op(16'h00FF, 16'h0100, "bp");
    expect_result(32'h0000FF00, "bp");
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_C", bus.C, 32'h0000FF00);
      check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    handshake("bp");
    check("bp_C_kept", bus.C, 32'h0000FF00);

    // New operands offered while busy are ignored
    accept_op(16'h0003, 16'h0005, "busy");
    bus.in_valid = 1'b1;
    bus.A        = 16'hAAAA;
    bus.B        = 16'h5555;
    expect_result(32'h0000000F, "busy");
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_C_stable", bus.C, 32'h0000000F);
    handshake("busy");
    @(posedge clk);
    #1;
    check("busy_no_restart", {31'd0, bus.in_ready}, 32'd1);

    // Asynchronous reset during CALC step 2 discards the operation
    accept_op(16'h8000, 16'h8000, "rst_mid");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid_C", bus.C, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("rst_mid_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    accept_op(16'h0002, 16'h0003, "after_rst");
    expect_result(32'h00000006, "after_rst");
    handshake("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
